viterbi_stream_decoder: RTL and testbench

Parametrised, streaming successor to `viterbi_top`. It is a hard-decision HMM Viterbi decoder with generic state count I, symbol alphabet K, maximum sequence length N and score width W. Observations arrive on a valid/ready stream. The recursion updates all I path metrics per cycle with saturating log-domain arithmetic. The decoded state sequence leaves on a second valid/ready stream in time order, followed by the final best score. It sits between the observation front-end and the sequence consumer and replaces the fixed-array `path` output of the previous generation.

---
 rtl/viterbi_stream_decoder.sv | 198 +++++++++++++++++++
 tb/tb_viterbi_stream_decoder.sv | 580 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_stream_decoder.sv
// Streaming hard-decision HMM Viterbi decoder: observations in on obs_*,
// decoded state path out on path_*, best_score/done/err at sequence end.
// Ports: clk, rst_n (sync, active-low), start/length, logA/logC/logB_flat,
//   obs_in/obs_valid/obs_ready, path_out/path_last/path_valid/path_ready,
//   best_score, busy, done, err.
module viterbi_stream_decoder #(
  parameter int N = 8,
  parameter int I = 3,
  parameter int K = 3,
  parameter int W = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [$clog2(N+1)-1:0] length,
  input  logic [I*I*W-1:0]       logA_flat,
  input  logic [I*W-1:0]         logC_flat,
  input  logic [I*K*W-1:0]       logB_flat,
  input  logic [$clog2(K)-1:0]   obs_in,
  input  logic                   obs_valid,
  output logic                   obs_ready,
  output logic [$clog2(I)-1:0]   path_out,
  output logic                   path_last,
  output logic                   path_valid,
  input  logic                   path_ready,
  output logic signed [W-1:0]    best_score,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int LW = $clog2(N+1);
  localparam int IW = $clog2(I);
  localparam int KW = $clog2(K);
  localparam int TW = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [W+1:0] SMAX =
    {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SMIN =
    {3'b111, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_TERM, S_TRACE, S_OUT
  } state_t;

  state_t state, state_nx;

  logic [LW-1:0] len, cnt, len_m1, cnt_m1;
  logic signed [W-1:0] delta [I];
  logic signed [W-1:0] delta_nx [I];
  logic [IW-1:0] bp [N][I];
  logic [IW-1:0] bp_nx [I];
  logic [IW-1:0] path_buf [N];
  logic [KW-1:0] sym;
  logic signed [W-1:0] term_max;
  logic [IW-1:0] term_arg;
  logic len_ok;

  function automatic logic signed [W+1:0] ext(
    input logic [W-1:0] x
  );
    return {{2{x[W-1]}}, x};
  endfunction

  function automatic logic signed [W-1:0] sat(
    input logic signed [W+1:0] x
  );
    if (x > SMAX) return SMAX[W-1:0];
    else if (x < SMIN) return SMIN[W-1:0];
    else return x[W-1:0];
  endfunction

  assign len_ok = (length != '0) && (length <= LW'(N));
  assign len_m1 = len - LW'(1);
  assign cnt_m1 = cnt - LW'(1);

  // Out-of-range symbols fold onto the last symbol
  assign sym = ({1'b0, obs_in} >= (KW+1)'(K))
             ? KW'(K-1) : obs_in;

  assign busy       = (state != S_IDLE);
  assign obs_ready  = (state == S_RECV);
  assign path_valid = (state == S_OUT);
  assign path_last  = path_valid && (cnt == len_m1);
  assign path_out   = path_valid ? path_buf[cnt[TW-1:0]] : '0;

  // Add-compare-select for all states; strict > keeps lowest i on ties
  always_comb begin
    logic signed [W-1:0] cand, best, base;
    logic [IW-1:0] arg;
    cand = '0;
    best = '0;
    base = '0;
    arg  = '0;
    for (int j = 0; j < I; j++) begin
      best = '0;
      arg  = '0;
      for (int i = 0; i < I; i++) begin
        cand = sat(ext(delta[i]) +
                   ext(logA_flat[(i*I+j)*W +: W]));
        if (i == 0 || cand > best) begin
          best = cand;
          arg  = IW'(i);
        end
      end
      base = (cnt == '0) ? logC_flat[j*W +: W] : best;
      delta_nx[j] = sat(ext(base) +
        ext(logB_flat[(j*K+int'(sym))*W +: W]));
      bp_nx[j] = arg;
    end
  end

  always_comb begin
    term_max = delta[0];
    term_arg = '0;
    for (int j = 1; j < I; j++) begin
      if (delta[j] > term_max) begin
        term_max = delta[j];
        term_arg = IW'(j);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (start && len_ok) state_nx = S_RECV;
      S_RECV:
        if (obs_valid && cnt == len_m1) state_nx = S_TERM;
      S_TERM:
        state_nx = (len_m1 == '0) ? S_OUT : S_TRACE;
      S_TRACE:
        if (cnt == LW'(1)) state_nx = S_OUT;
      S_OUT:
        if (path_ready && cnt == len_m1) state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // One counter serves as t in RECV, trace cursor in TRACE, beat index in OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len        <= '0;
      cnt        <= '0;
      best_score <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE:
          if (start) begin
            len <= length;
            cnt <= '0;
            if (!len_ok) begin
              done <= 1'b1;
              err  <= 1'b1;
            end
          end
        S_RECV:
          if (obs_valid) cnt <= cnt + LW'(1);
        S_TERM: begin
          best_score <= term_max;
          cnt        <= len_m1;
        end
        S_TRACE:
          cnt <= cnt_m1;
        S_OUT:
          if (path_ready) begin
            cnt <= cnt + LW'(1);
            if (cnt == len_m1) done <= 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RECV && obs_valid) begin
      delta <= delta_nx;
      bp[cnt[TW-1:0]] <= bp_nx;
    end
    if (state == S_TERM)
      path_buf[len_m1[TW-1:0]] <= term_arg;
    if (state == S_TRACE)
      path_buf[cnt_m1[TW-1:0]] <=
        bp[cnt[TW-1:0]][path_buf[cnt[TW-1:0]]];
  end

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// Self-checking bench for viterbi_stream_decoder against a
// trellis-level reference model.
module tb_viterbi_stream_decoder;

  localparam int N  = 8;
  localparam int I  = 3;
  localparam int K  = 3;
  localparam int W  = 20;
  localparam int LW = $clog2(N+1);
  localparam int IW = $clog2(I);
  localparam int KW = $clog2(K);
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [LW-1:0] length = '0;
  logic [I*I*W-1:0] logA_flat = '0;
  logic [I*W-1:0] logC_flat = '0;
  logic [I*K*W-1:0] logB_flat = '0;
  logic [KW-1:0] obs_in = '0;
  logic obs_valid = 1'b0;
  logic obs_ready;
  logic [IW-1:0] path_out;
  logic path_last, path_valid;
  logic path_ready = 1'b0;
  logic signed [W-1:0] best_score;
  logic busy, done, err;

  viterbi_stream_decoder #(.N(N), .I(I), .K(K), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length),
    .logA_flat(logA_flat), .logC_flat(logC_flat),
    .logB_flat(logB_flat), .obs_in(obs_in),
    .obs_valid(obs_valid), .obs_ready(obs_ready),
    .path_out(path_out), .path_last(path_last),
    .path_valid(path_valid), .path_ready(path_ready),
    .best_score(best_score), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  longint pA [I][I];
  longint pC [I];
  longint pB [I][K];
  int obs_q [N];
  int exp_path [N];
  longint exp_score;
  int pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};

  int got_path [N];
  int got_last [N];
  int nbeats, lat, stall_bad, done_early;
  int done_end, busy_end, tmo;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint clampw(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  // Full trellis, then backtrack from the best final state
  task automatic model(input int L);
    longint dp [N][I];
    int bk [N][I];
    longint v, b;
    int o, bi;
    for (int t = 0; t < L; t++) begin
      o = (obs_q[t] >= K) ? K-1 : obs_q[t];
      for (int j = 0; j < I; j++) begin
        if (t == 0) begin
          dp[0][j] = clampw(pC[j] + pB[j][o]);
          bk[0][j] = 0;
        end else begin
          b = 0;
          bi = 0;
          for (int i = 0; i < I; i++) begin
            v = clampw(dp[t-1][i] + pA[i][j]);
            if (i == 0 || v > b) begin
              b = v;
              bi = i;
            end
          end
          dp[t][j] = clampw(b + pB[j][o]);
          bk[t][j] = bi;
        end
      end
    end
    exp_score = dp[L-1][0];
    exp_path[L-1] = 0;
    for (int j = 1; j < I; j++)
      if (dp[L-1][j] > exp_score) begin
        exp_score = dp[L-1][j];
        exp_path[L-1] = j;
      end
    for (int t = L-1; t >= 1; t--)
      exp_path[t-1] = bk[t][exp_path[t]];
  endtask

  task automatic pack_params();
    for (int i = 0; i < I; i++) begin
      logC_flat[i*W +: W] = W'(pC[i]);
      for (int j = 0; j < I; j++)
        logA_flat[(i*I+j)*W +: W] = W'(pA[i][j]);
      for (int k = 0; k < K; k++)
        logB_flat[(i*K+k)*W +: W] = W'(pB[i][k]);
    end
  endtask

  task automatic set_nominal();
    for (int i = 0; i < I; i++) begin
      for (int j = 0; j < I; j++)
        pA[i][j] = (i == j) ? -10 : -100;
      for (int k = 0; k < K; k++)
        pB[i][k] = (i == k) ? -5 : -100;
    end
    pA[0][1] = -50;
    pA[1][2] = -50;
    pA[2][0] = -50;
    pC[0] = -10;
    pC[1] = -50;
    pC[2] = -50;
    pack_params();
  endtask

  task automatic set_const(input longint v);
    for (int i = 0; i < I; i++) begin
      pC[i] = v;
      for (int j = 0; j < I; j++) pA[i][j] = v;
      for (int k = 0; k < K; k++) pB[i][k] = v;
    end
    pack_params();
  endtask

  task automatic set_nominal_obs();
    obs_q[0] = 0;
    obs_q[1] = 0;
    obs_q[2] = 1;
    obs_q[3] = 1;
    obs_q[4] = 2;
  endtask

  // Drives one sequence from the current cycle and records what came out
  task automatic run_seq(input int L, input int gap,
                         input int rmode, input int poke);
    int idx, cyc, held, pv_prev;
    logic [IW-1:0] po_prev;
    nbeats = 0;
    lat = 0;
    stall_bad = 0;
    done_early = 0;
    done_end = 0;
    busy_end = 1;
    tmo = 0;
    po_prev = '0;
    for (int b = 0; b < N; b++) begin
      got_path[b] = -1;
      got_last[b] = -1;
    end
    start = 1'b1;
    length = LW'(L);
    step();
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < L && cyc < 200) begin
      obs_valid = (gap != 0 && cyc % 2 == 1) ? 1'b0 : 1'b1;
      obs_in = KW'(obs_q[idx]);
      if (poke != 0) begin
        start = 1'($urandom_range(0, 1));
        length = LW'($urandom);
      end
      held = (obs_valid && obs_ready) ? 1 : 0;
      if (done) done_early++;
      step();
      cyc++;
      if (held != 0) idx++;
    end
    obs_valid = 1'b0;
    start = 1'b0;
    if (idx < L) tmo = 1;
    lat = 1;
    while (!path_valid && lat < 200 && tmo == 0) begin
      if (done) done_early++;
      step();
      lat++;
    end
    if (!path_valid) tmo = 1;
    cyc = 0;
    pv_prev = 0;
    while (nbeats < L && cyc < 400 && tmo == 0) begin
      case (rmode)
        0: path_ready = 1'b1;
        1: path_ready = 1'(pat[cyc % 8]);
        default: path_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke != 0) begin
        start = 1'($urandom_range(0, 1));
        length = LW'($urandom);
      end
      if (pv_prev != 0 && (!path_valid || path_out !== po_prev))
        stall_bad++;
      if (done) done_early++;
      if (path_valid && path_ready) begin
        got_path[nbeats] = int'(path_out);
        got_last[nbeats] = int'(path_last);
        nbeats++;
      end
      pv_prev = (path_valid && !path_ready) ? 1 : 0;
      po_prev = path_out;
      step();
      cyc++;
    end
    path_ready = 1'b0;
    start = 1'b0;
    if (nbeats < L) tmo = 1;
    done_end = int'(done);
    busy_end = int'(busy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    nvec++;
    if ({obs_ready, path_valid, path_last, busy, done, err} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_flags got=%b exp=000000",
        {obs_ready, path_valid, path_last, busy, done, err});
    end
    nvec++;
    if (path_out !== '0 || best_score !== '0) begin
      nerr++;
      $display("FAIL reset_data got path=%0d score=%0d exp 0/0",
        path_out, best_score);
    end
    rst_n = 1'b1;
    step();
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle got busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_nominal();
    int ep [5] = '{0, 0, 1, 1, 2};
    set_nominal();
    set_nominal_obs();
    run_seq(5, 0, 0, 0);
    nvec++;
    if (tmo !== 0 || nbeats !== 5) begin
      nerr++;
      $display("FAIL nom_beats got=%0d exp=5 tmo=%0d", nbeats, tmo);
    end
    for (int b = 0; b < 5; b++) begin
      nvec++;
      if (got_path[b] !== ep[b] || got_last[b] !== int'(b == 4)) begin
        nerr++;
        $display("FAIL nom_beat%0d got=%0d/%0d exp=%0d/%0d",
          b, got_path[b], got_last[b], ep[b], int'(b == 4));
      end
    end
    nvec++;
    if (best_score !== -20'sd155) begin
      nerr++;
      $display("FAIL nom_score got=%0d exp=-155", best_score);
    end
    nvec++;
    if (lat !== 6) begin
      nerr++;
      $display("FAIL nom_latency got=%0d exp=6", lat);
    end
    nvec++;
    if (done_end !== 1 || busy_end !== 0 || done_early !== 0) begin
      nerr++;
      $display("FAIL nom_done got done=%0d busy=%0d early=%0d exp 1/0/0",
        done_end, busy_end, done_early);
    end
  endtask

  task automatic test_backpressure();
    int ep [5] = '{0, 0, 1, 1, 2};
    set_nominal();
    set_nominal_obs();
    run_seq(5, 1, 1, 0);
    nvec++;
    if (tmo !== 0 || nbeats !== 5) begin
      nerr++;
      $display("FAIL bp_beats got=%0d exp=5 tmo=%0d", nbeats, tmo);
    end
    for (int b = 0; b < 5; b++) begin
      nvec++;
      if (got_path[b] !== ep[b] || got_last[b] !== int'(b == 4)) begin
        nerr++;
        $display("FAIL bp_beat%0d got=%0d/%0d exp=%0d/%0d",
          b, got_path[b], got_last[b], ep[b], int'(b == 4));
      end
    end
    nvec++;
    if (best_score !== -20'sd155 || stall_bad !== 0) begin
      nerr++;
      $display("FAIL bp_score_stall got=%0d/%0d exp=-155/0",
        best_score, stall_bad);
    end
    nvec++;
    if (done_end !== 1 || done_early !== 0) begin
      nerr++;
      $display("FAIL bp_done got=%0d early=%0d exp 1/0",
        done_end, done_early);
    end
  endtask

  task automatic test_tie();
    set_const(0);
    for (int t = 0; t < 4; t++) obs_q[t] = $urandom_range(0, 3);
    run_seq(4, 0, 0, 0);
    nvec++;
    if (tmo !== 0 || nbeats !== 4) begin
      nerr++;
      $display("FAIL tie_beats got=%0d exp=4 tmo=%0d", nbeats, tmo);
    end
    for (int b = 0; b < 4; b++) begin
      nvec++;
      if (got_path[b] !== 0) begin
        nerr++;
        $display("FAIL tie_beat%0d got=%0d exp=0", b, got_path[b]);
      end
    end
    nvec++;
    if (best_score !== '0) begin
      nerr++;
      $display("FAIL tie_score got=%0d exp=0", best_score);
    end
  endtask

  task automatic test_len1();
    set_nominal();
    obs_q[0] = 2;
    run_seq(1, 0, 0, 0);
    nvec++;
    if (tmo !== 0 || nbeats !== 1 || got_path[0] !== 2
        || got_last[0] !== 1) begin
      nerr++;
      $display("FAIL len1_beat got n=%0d p=%0d last=%0d exp 1/2/1",
        nbeats, got_path[0], got_last[0]);
    end
    nvec++;
    if (best_score !== -20'sd55 || lat !== 2) begin
      nerr++;
      $display("FAIL len1_score_lat got=%0d/%0d exp=-55/2",
        best_score, lat);
    end
  endtask

  task automatic test_saturation();
    set_const(-300000);
    for (int t = 0; t < N; t++) obs_q[t] = $urandom_range(0, 3);
    run_seq(N, 0, 0, 0);
    nvec++;
    if (tmo !== 0 || nbeats !== N) begin
      nerr++;
      $display("FAIL sat_beats got=%0d exp=%0d tmo=%0d", nbeats, N, tmo);
    end
    for (int b = 0; b < N; b++) begin
      nvec++;
      if (got_path[b] !== 0) begin
        nerr++;
        $display("FAIL sat_beat%0d got=%0d exp=0", b, got_path[b]);
      end
    end
    nvec++;
    if (longint'(best_score) !== MINV) begin
      nerr++;
      $display("FAIL sat_score got=%0d exp=%0d", best_score, MINV);
    end
  endtask

  task automatic test_illegal();
    int bad;
    int lens [2] = '{0, N+1};
    for (int n = 0; n < 2; n++) begin
      start = 1'b1;
      length = LW'(lens[n]);
      step();
      start = 1'b0;
      nvec++;
      if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
        nerr++;
        $display("FAIL illegal_len%0d got done=%b err=%b busy=%b exp 1/1/0",
          lens[n], done, err, busy);
      end
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (obs_ready || path_valid) bad++;
        step();
        if (done || err) bad++;
      end
      nvec++;
      if (bad !== 0) begin
        nerr++;
        $display("FAIL illegal_quiet%0d got=%0d exp=0", lens[n], bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    set_nominal();
    set_nominal_obs();
    run_seq(5, 0, 0, 0);
    nvec++;
    if (done_end !== 1) begin
      nerr++;
      $display("FAIL b2b_first_done got=%0d exp=1", done_end);
    end
    obs_q[0] = 2;
    obs_q[1] = 0;
    obs_q[2] = 3;
    model(3);
    run_seq(3, 0, 0, 0);
    nvec++;
    if (tmo !== 0 || nbeats !== 3) begin
      nerr++;
      $display("FAIL b2b_beats got=%0d exp=3 tmo=%0d", nbeats, tmo);
    end
    for (int b = 0; b < 3; b++) begin
      nvec++;
      if (got_path[b] !== exp_path[b]) begin
        nerr++;
        $display("FAIL b2b_beat%0d got=%0d exp=%0d",
          b, got_path[b], exp_path[b]);
      end
    end
    nvec++;
    if (longint'(best_score) !== exp_score) begin
      nerr++;
      $display("FAIL b2b_score got=%0d exp=%0d", best_score, exp_score);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    int ep [5] = '{0, 0, 1, 1, 2};
    set_nominal();
    set_nominal_obs();
    start = 1'b1;
    length = LW'(5);
    step();
    start = 1'b0;
    for (int t = 0; t < 5; t++) begin
      obs_valid = 1'b1;
      obs_in = KW'(obs_q[t]);
      step();
    end
    obs_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    nvec++;
    if ({obs_ready, path_valid, path_last, busy, done, err} !== 6'b0
        || path_out !== '0 || best_score !== '0) begin
      nerr++;
      $display("FAIL rstmid_values got=%b p=%0d s=%0d exp 000000/0/0",
        {obs_ready, path_valid, path_last, busy, done, err},
        path_out, best_score);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done || path_valid || busy) bad++;
    end
    nvec++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL rstmid_quiet got=%0d exp=0", bad);
    end
    run_seq(5, 0, 0, 0);
    nvec++;
    if (tmo !== 0 || nbeats !== 5 || done_end !== 1) begin
      nerr++;
      $display("FAIL rstmid_rerun got n=%0d done=%0d tmo=%0d exp 5/1/0",
        nbeats, done_end, tmo);
    end
    for (int b = 0; b < 5; b++) begin
      nvec++;
      if (got_path[b] !== ep[b]) begin
        nerr++;
        $display("FAIL rstmid_beat%0d got=%0d exp=%0d",
          b, got_path[b], ep[b]);
      end
    end
  endtask

  task automatic test_random();
    int L, mode;
    for (int it = 0; it < 25; it++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < I; i++) begin
        for (int j = 0; j < I; j++)
          pA[i][j] = (mode == 0)
            ? -longint'($urandom_range(0, 100))
            : longint'($urandom_range(0, 1048575)) - 524288;
        for (int k = 0; k < K; k++)
          pB[i][k] = (mode == 0)
            ? -longint'($urandom_range(0, 100))
            : longint'($urandom_range(0, 1048575)) - 524288;
        pC[i] = (mode == 2)
          ? longint'($urandom_range(0, 1048575)) - 524288
          : -longint'($urandom_range(0, 100));
      end
      pack_params();
      L = $urandom_range(1, N);
      for (int t = 0; t < L; t++) obs_q[t] = $urandom_range(0, 3);
      model(L);
      run_seq(L, $urandom_range(0, 1), 2, 1);
      nvec++;
      if (tmo !== 0 || nbeats !== L || stall_bad !== 0
          || lat !== L+1) begin
        nerr++;
        $display("FAIL rnd%0d_flow got n=%0d st=%0d lat=%0d tmo=%0d exp %0d/0/%0d/0",
          it, nbeats, stall_bad, lat, tmo, L, L+1);
      end
      for (int b = 0; b < L; b++) begin
        nvec++;
        if (got_path[b] !== exp_path[b]
            || got_last[b] !== int'(b == L-1)) begin
          nerr++;
          $display("FAIL rnd%0d_beat%0d got=%0d/%0d exp=%0d/%0d",
            it, b, got_path[b], got_last[b], exp_path[b],
            int'(b == L-1));
        end
      end
      nvec++;
      if (longint'(best_score) !== exp_score) begin
        nerr++;
        $display("FAIL rnd%0d_score got=%0d exp=%0d",
          it, best_score, exp_score);
      end
      nvec++;
      if (done_end !== 1 || busy_end !== 0 || done_early !== 0) begin
        nerr++;
        $display("FAIL rnd%0d_done got=%0d/%0d/%0d exp 1/0/0",
          it, done_end, busy_end, done_early);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_tie();
    test_len1();
    test_saturation();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

endmodule
